// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Counter must reach WIDTH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fsub_bit.sv
// Combinational full-subtractor cell: d = a - b - bi, with borrow out.
module fsub_bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             OV
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic               bw;
  logic [CNT_W-1:0]   cnt;
  logic               a_msb;
  logic               b_msb;
  logic               d_bit;
  logic               bw_nxt;
  logic               last_c;
  logic [WIDTH-1:0]   d_shift_c;

  fsub_bit u_cell (
    .a  (sa[0]),
    .b  (sb[0]),
    .bi (bw),
    .d  (d_bit),
    .bo (bw_nxt)
  );

  assign last_c = (cnt == CNT_W'(WIDTH - 1));

  // Result enters from the MSB end so the final bit lands at D[WIDTH-1].
  if (WIDTH == 1) begin : g_shift_w1
    assign d_shift_c = d_bit;
  end else begin : g_shift_wn
    assign d_shift_c = {d_bit, D[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IN_VALID) state_nxt = RUN;
      RUN:     if (last_c) state_nxt = DONE;
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state register
  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state)
      IDLE:    IN_READY  = 1'b1;
      DONE:    OUT_VALID = 1'b1;
      default: ;
    endcase
  end

  // Operand shifters, borrow, counter and result flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      sa    <= '0;
      sb    <= '0;
      bw    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      D     <= '0;
      BO    <= 1'b0;
      OV    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            sa    <= A;
            sb    <= B;
            bw    <= 1'b0;
            cnt   <= '0;
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          bw  <= bw_nxt;
          cnt <= cnt + CNT_W'(1);
          D   <= d_shift_c;
          // Last bit processed: d_bit is the result MSB
          if (last_c) begin
            BO <= bw_nxt;
            OV <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid8, out_ready8, in_ready8, out_valid8, bo8, ov8;
  logic [7:0] a8, b8, d8;
  logic       in_valid1, out_ready1, in_ready1, out_valid1, bo1, ov1;
  logic [0:0] a1, b1, d1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid8), .IN_READY(in_ready8),
    .A(a8), .B(b8), .OUT_VALID(out_valid8), .OUT_READY(out_ready8),
    .D(d8), .BO(bo8), .OV(ov8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid1), .IN_READY(in_ready1),
    .A(a1), .B(b1), .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
    .D(d1), .BO(bo1), .OV(ov1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, wait (bounded) for the result, then drain it.
  task automatic do_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                       input int gap_in, input int gap_out,
                       output logic [7:0] d, output logic bo, output logic ov,
                       output int lat, output bit to);
    repeat (gap_in) tick;
    if (w1) begin in_valid1 = 1'b1; a1 = a[0]; b1 = b[0]; end
    else    begin in_valid8 = 1'b1; a8 = a;    b8 = b;    end
    tick;
    in_valid1 = 1'b0;
    in_valid8 = 1'b0;
    lat = 0;
    while (!(w1 ? out_valid1 : out_valid8) && lat < 40) begin
      tick;
      lat++;
    end
    to = (lat >= 40);
    repeat (gap_out) tick;
    d  = w1 ? {7'd0, d1} : d8;
    bo = w1 ? bo1 : bo8;
    ov = w1 ? ov1 : ov8;
    if (w1) out_ready1 = 1'b1;
    else    out_ready8 = 1'b1;
    tick;
    out_ready1 = 1'b0;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready8); end
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid8); end
    total++; if ({d8, bo8, ov8} !== 10'd0) begin bad++; $display("FAIL reset_outputs got=%h/%b/%b exp=00/0/0", d8, bo8, ov8); end
    total++; if ({in_ready1, out_valid1} !== 2'b10) begin bad++; $display("FAIL reset_w1 got=%b%b exp=10", in_ready1, out_valid1); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_vectors;
    logic [7:0] va [4] = '{8'h05, 8'h03, 8'h80, 8'h7F};
    logic [7:0] vb [4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
    logic [7:0] vd [4] = '{8'h02, 8'hFE, 8'h7F, 8'h80};
    logic       vbo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       vov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] d;
    logic bo, ov;
    int lat;
    bit to;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, va[i], vb[i], 0, 0, d, bo, ov, lat, to);
      total++; if (lat !== 8) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=8", i, lat); end
      total++; if (d !== vd[i]) begin bad++; $display("FAIL vec%0d_d got=%h exp=%h", i, d, vd[i]); end
      total++; if (bo !== vbo[i]) begin bad++; $display("FAIL vec%0d_bo got=%b exp=%b", i, bo, vbo[i]); end
      total++; if (ov !== vov[i]) begin bad++; $display("FAIL vec%0d_ov got=%b exp=%b", i, ov, vov[i]); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    in_valid8 = 1'b1; a8 = 8'h0A; b8 = 8'h0C;
    tick;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 40) begin tick; n++; end
    total++; if (n >= 40) begin bad++; $display("FAIL bp_timeout got=%0d exp<40", n); end
    in_valid8 = 1'b1; a8 = 8'h33; b8 = 8'h11; out_ready8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if ({out_valid8, in_ready8, d8, bo8, ov8} !== {1'b1, 1'b0, 8'hFE, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d got=v%b r%b %h/%b/%b exp=v1 r0 fe/1/0", i, out_valid8, in_ready8, d8, bo8, ov8);
      end
    end
    out_ready8 = 1'b1;
    tick;
    out_ready8 = 1'b0;
    total++; if ({in_ready8, out_valid8} !== 2'b10) begin bad++; $display("FAIL bp_idle got=%b%b exp=10", in_ready8, out_valid8); end
    tick;
    in_valid8 = 1'b0;
    total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL bp_accept got=%b exp=0", in_ready8); end
    n = 0;
    while (!out_valid8 && n < 40) begin tick; n++; end
    total++; if ({d8, bo8, ov8} !== {8'h22, 1'b0, 1'b0}) begin bad++; $display("FAIL bp_second got=%h/%b/%b exp=22/0/0", d8, bo8, ov8); end
    out_ready8 = 1'b1;
    tick;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] d;
    logic bo, ov;
    int lat, seen;
    bit to;
    in_valid8 = 1'b1; a8 = 8'h55; b8 = 8'h22;
    tick;
    in_valid8 = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if ({in_ready8, out_valid8} !== 2'b10) begin bad++; $display("FAIL midrst_state got=%b%b exp=10", in_ready8, out_valid8); end
    total++; if ({d8, bo8, ov8} !== 10'd0) begin bad++; $display("FAIL midrst_outputs got=%h/%b/%b exp=00/0/0", d8, bo8, ov8); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (out_valid8) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d exp=0", seen); end
    do_op(1'b0, 8'h10, 8'h01, 0, 0, d, bo, ov, lat, to);
    total++; if ({d, bo, ov} !== {8'h0F, 1'b0, 1'b0}) begin bad++; $display("FAIL midrst_next got=%h/%b/%b exp=0f/0/0", d, bo, ov); end
  endtask

  task automatic test_reset_release;
    int n;
    rst = 1'b1;
    tick;
    in_valid8 = 1'b1; a8 = 8'h20; b8 = 8'h21;
    tick;
    rst = 1'b0;
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL rel_not_accepted got=%b exp=1", in_ready8); end
    tick;
    in_valid8 = 1'b0;
    total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL rel_accepted got=%b exp=0", in_ready8); end
    n = 0;
    while (!out_valid8 && n < 40) begin tick; n++; end
    total++; if ({d8, bo8, ov8} !== {8'hFF, 1'b1, 1'b0}) begin bad++; $display("FAIL rel_result got=%h/%b/%b exp=ff/1/0", d8, bo8, ov8); end
    out_ready8 = 1'b1;
    tick;
    out_ready8 = 1'b0;
  endtask

  task automatic test_width1;
    logic [2:0] exp_t [4] = '{3'b000, 3'b111, 3'b100, 3'b000};
    logic [7:0] a, b, d;
    logic bo, ov;
    int lat;
    bit to;
    for (int i = 0; i < 4; i++) begin
      a = 8'(i >> 1);
      b = 8'(i & 1);
      do_op(1'b1, a, b, 0, 0, d, bo, ov, lat, to);
      total++; if (lat !== 1) begin bad++; $display("FAIL w1_%0d_latency got=%0d exp=1", i, lat); end
      total++; if ({d[0], bo, ov} !== exp_t[i]) begin bad++; $display("FAIL w1_%0d got=%b%b%b exp=%b", i, d[0], bo, ov, exp_t[i]); end
    end
  endtask

  task automatic test_random(input bit w1, input int n_ops);
    logic [7:0] a, b, d, ed, msk;
    logic bo, ov, ebo, eov;
    int lat, msb;
    bit to;
    msk = w1 ? 8'h01 : 8'hFF;
    msb = w1 ? 0 : 7;
    for (int i = 0; i < n_ops; i++) begin
      a = 8'($urandom) & msk;
      b = 8'($urandom) & msk;
      ed  = (a - b) & msk;
      ebo = (a < b);
      eov = (a[msb] != b[msb]) && (ed[msb] != a[msb]);
      do_op(w1, a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d, bo, ov, lat, to);
      total++;
      if (to || d !== ed || bo !== ebo || ov !== eov) begin
        bad++;
        $display("FAIL rand_w%0d_%0d a=%h b=%h got=%h/%b/%b to=%b exp=%h/%b/%b", w1 ? 1 : 8, i, a, b, d, bo, ov, to, ed, ebo, eov);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
    #2;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_reset_release();
    test_width1();
    test_random(1'b0, 1000);
    test_random(1'b1, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
